// File: rtl/layer_sequencer.sv
// layer_sequencer: steps through a descriptor table, launching conv/pool/fc engines layer by layer.
// Ports: clk, rst_n (async, active-low) | start_flag, abort: run control | cfg_we/cfg_idx/cfg_desc:
// descriptor table write, cfg_nlayers: run length | start_*/end_*: engine handshake |
// ifmap_*/outfmap_c/offset_*: current layer geometry | buf_sel, layer_idx: ping-pong buffer and layer |
// fc_res_* in, nn_out_* out: captured fc result | busy/done/error: status
module layer_sequencer #(
  parameter int NUM_LAYERS  = 8,
  parameter int DONE_HOLD   = 3,
  parameter int TIMEOUT_CYC = 1048575,
  localparam int LIDX_W     = $clog2(NUM_LAYERS)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start_flag,
  input  logic              abort,
  input  logic              cfg_we,
  input  logic [LIDX_W-1:0] cfg_idx,
  input  logic [49:0]       cfg_desc,
  input  logic [LIDX_W:0]   cfg_nlayers,
  output logic              start_conv,
  output logic              start_pool,
  output logic              start_fc,
  input  logic              end_conv,
  input  logic              end_pool,
  input  logic              end_fc,
  output logic [5:0]        ifmap_h,
  output logic [5:0]        ifmap_w,
  output logic [5:0]        ifmap_c,
  output logic [5:0]        outfmap_c,
  output logic [14:0]       offset_w,
  output logic [8:0]        offset_ow,
  output logic              buf_sel,
  output logic [LIDX_W-1:0] layer_idx,
  input  logic [7:0]        fc_res_0,
  input  logic [7:0]        fc_res_1,
  output logic [7:0]        nn_out_0,
  output logic [7:0]        nn_out_1,
  output logic              busy,
  output logic              done,
  output logic              error
);
  localparam int TW = $clog2(TIMEOUT_CYC + 1);
  localparam int HW = $clog2(DONE_HOLD + 1);
  localparam logic [2:0] S_IDLE = 3'd0, S_LOAD = 3'd1, S_RUN = 3'd2, S_DONE = 3'd3, S_ERR = 3'd4;
  localparam logic [1:0] T_CONV = 2'd0, T_POOL = 2'd1, T_FC = 2'd2, T_ILL = 2'd3;
  localparam logic [LIDX_W:0] NL_MAX    = (LIDX_W + 1)'(NUM_LAYERS);
  localparam logic [TW-1:0]   TO_LAST   = TW'(TIMEOUT_CYC - 1);
  localparam logic [HW-1:0]   HOLD_LAST = HW'(DONE_HOLD - 1);
  logic [2:0]        r_state;
  logic [1:0]        r_type;
  logic [5:0]        r_h, r_w, r_c, r_oc;
  logic [14:0]       r_ow;
  logic [8:0]        r_oow;
  logic              r_buf;
  logic [LIDX_W-1:0] r_lidx;
  logic [LIDX_W:0]   r_nl;
  logic [7:0]        r_nn0, r_nn1;
  logic [TW-1:0]     r_tcnt;
  logic [HW-1:0]     r_hcnt;
  logic [49:0]       r_tab [NUM_LAYERS];
  logic [49:0]       w_desc;
  logic              w_run, w_end, w_last, w_nl_ok;
  assign w_desc  = r_tab[r_lidx];
  assign w_run   = r_state == S_RUN;
  assign w_end   = (r_type == T_CONV && end_conv) || (r_type == T_POOL && end_pool) || (r_type == T_FC && end_fc);
  assign w_last  = ({1'b0, r_lidx} + 1'b1) == r_nl;
  assign w_nl_ok = cfg_nlayers != '0 && cfg_nlayers <= NL_MAX;
  // Engine enables decode straight from the state register so an async reset drops them immediately.
  assign start_conv = w_run && r_type == T_CONV;
  assign start_pool = w_run && r_type == T_POOL;
  assign start_fc   = w_run && r_type == T_FC;
  assign {ifmap_h, ifmap_w, ifmap_c, outfmap_c, offset_w, offset_ow} = {r_h, r_w, r_c, r_oc, r_ow, r_oow};
  assign buf_sel   = r_buf;
  assign layer_idx = r_lidx;
  assign nn_out_0  = r_nn0;
  assign nn_out_1  = r_nn1;
  assign busy      = r_state != S_IDLE;
  assign done      = r_state == S_DONE;
  assign error     = r_state == S_ERR;
  // Table has no reset so it survives a reset between runs.
  always_ff @(posedge clk)
    if (cfg_we && r_state == S_IDLE) r_tab[cfg_idx] <= cfg_desc;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      r_state <= S_IDLE;
      {r_type, r_h, r_w, r_c, r_oc, r_ow, r_oow} <= '0;
      r_buf   <= 1'b0;
      r_lidx  <= '0;
      r_nl    <= '0;
      r_nn0   <= '0;
      r_nn1   <= '0;
      r_tcnt  <= '0;
      r_hcnt  <= '0;
    end else if (abort) begin
      r_state <= S_IDLE;
      r_tcnt  <= '0;
      r_hcnt  <= '0;
    end else case (r_state)
      S_IDLE: if (start_flag && w_nl_ok) begin
        r_state <= S_LOAD;
        r_lidx  <= '0;
        r_buf   <= 1'b0;
        r_nn0   <= '0;
        r_nn1   <= '0;
        r_nl    <= cfg_nlayers;
      end
      S_LOAD: begin
        {r_type, r_h, r_w, r_c, r_oc, r_ow, r_oow} <= w_desc;
        r_tcnt  <= '0;
        r_state <= w_desc[49:48] == T_ILL ? S_ERR : S_RUN;
      end
      S_RUN: if (w_end) begin
        r_tcnt <= '0;
        if (r_type == T_FC) begin
          r_nn0 <= fc_res_0;
          r_nn1 <= fc_res_1;
        end
        if (w_last) begin
          r_state <= S_DONE;
          r_hcnt  <= '0;
        end else begin
          r_state <= S_LOAD;
          r_lidx  <= r_lidx + 1'b1;
          r_buf   <= ~r_buf;
        end
      end else if (r_tcnt == TO_LAST) begin
        r_state <= S_ERR;
        r_tcnt  <= '0;
      end else r_tcnt <= r_tcnt + 1'b1;
      S_DONE: if (r_hcnt == HOLD_LAST) begin
        r_state <= S_IDLE;
        r_hcnt  <= '0;
      end else r_hcnt <= r_hcnt + 1'b1;
      default: ;
    endcase
endmodule

// File: tb/tb_layer_sequencer.sv
// tb_layer_sequencer: directed scoreboard bench for layer_sequencer.
module tb_layer_sequencer;
  localparam int NL = 8, LW = 3;
  logic clk = 1'b0, rst_n = 1'b0, start_flag = 1'b0, abort = 1'b0, cfg_we = 1'b0;
  logic [LW-1:0] cfg_idx = '0;
  logic [49:0] cfg_desc = '0;
  logic [LW:0] cfg_nlayers = '0;
  logic start_conv, start_pool, start_fc;
  logic end_conv = 1'b0, end_pool = 1'b0, end_fc = 1'b0;
  logic [5:0] ifmap_h, ifmap_w, ifmap_c, outfmap_c;
  logic [14:0] offset_w;
  logic [8:0] offset_ow;
  logic buf_sel, busy, done, error;
  logic [LW-1:0] layer_idx;
  logic [7:0] fc_res_0 = '0, fc_res_1 = '0, nn_out_0, nn_out_1;
  int n_chk = 0, n_err = 0;
  typedef struct {
    logic [2:0]    sv;
    logic          bs;
    logic [LW-1:0] li;
    logic [47:0]   geo;
  } exp_t;
  exp_t sb[$];
  logic [49:0] m_tab [NL];
  exp_t e;
  always #5 clk = ~clk;
  layer_sequencer #(.NUM_LAYERS(NL), .DONE_HOLD(3), .TIMEOUT_CYC(16)) dut (
    .clk(clk), .rst_n(rst_n), .start_flag(start_flag), .abort(abort),
    .cfg_we(cfg_we), .cfg_idx(cfg_idx), .cfg_desc(cfg_desc), .cfg_nlayers(cfg_nlayers),
    .start_conv(start_conv), .start_pool(start_pool), .start_fc(start_fc),
    .end_conv(end_conv), .end_pool(end_pool), .end_fc(end_fc),
    .ifmap_h(ifmap_h), .ifmap_w(ifmap_w), .ifmap_c(ifmap_c), .outfmap_c(outfmap_c),
    .offset_w(offset_w), .offset_ow(offset_ow), .buf_sel(buf_sel), .layer_idx(layer_idx),
    .fc_res_0(fc_res_0), .fc_res_1(fc_res_1), .nn_out_0(nn_out_0), .nn_out_1(nn_out_1),
    .busy(busy), .done(done), .error(error)
  );
  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  function automatic logic [49:0] mk(input logic [1:0] t, input int k);
    return {t, 6'(k + 1), 6'(k + 9), 6'(k + 17), 6'(k + 33), 15'(k * 1000 + 7), 9'(k * 37 + 5)};
  endfunction
  function automatic logic [2:0] sv_of(input logic [1:0] t);
    return t == 2'd0 ? 3'b100 : t == 2'd1 ? 3'b010 : t == 2'd2 ? 3'b001 : 3'b000;
  endfunction
  function automatic logic [2:0] sv_now();
    return {start_conv, start_pool, start_fc};
  endfunction
  function automatic logic [47:0] geo_now();
    return {ifmap_h, ifmap_w, ifmap_c, outfmap_c, offset_w, offset_ow};
  endfunction
  task automatic wr(input int idx, input logic [49:0] d);
    cfg_idx = LW'(idx);
    cfg_desc = d;
    cfg_we = 1'b1;
    step();
    cfg_we = 1'b0;
    m_tab[idx] = d;
  endtask
  task automatic go(input int n, input int nrun);
    exp_t x;
    cfg_nlayers = (LW + 1)'(n);
    start_flag = 1'b1;
    for (int i = 0; i < nrun; i++) begin
      x.sv  = sv_of(m_tab[i][49:48]);
      x.bs  = 1'(i % 2);
      x.li  = LW'(i);
      x.geo = m_tab[i][47:0];
      sb.push_back(x);
    end
    step();
    start_flag = 1'b0;
  endtask
  task automatic pop(output exp_t x);
    n_chk++;
    assert (sb.size() > 0) else begin
      n_err++;
      $error("FAIL sb_empty: observed %0d expected >0", sb.size());
    end
    if (sb.size() > 0) x = sb.pop_front();
    else begin
      x.sv = '0; x.bs = 1'b0; x.li = '0; x.geo = '0;
    end
  endtask
  // Enter RUN from LOAD, check the layer against the scoreboard, then ack after cyc RUN cycles.
  task automatic serve(input int cyc, input bit glitch, input bit wrrun, input logic [7:0] r0, input logic [7:0] r1);
    exp_t x;
    chk("gap_load", sv_now(), 3'b000);
    step();
    pop(x);
    chk("start_vec", sv_now(), x.sv);
    chk("buf_sel", buf_sel, x.bs);
    chk("layer_idx", layer_idx, x.li);
    chk("geom", geo_now(), x.geo);
    for (int k = 1; k < cyc; k++) begin
      if (glitch && k == 3) begin
        end_pool = x.sv[2];
        end_conv = ~x.sv[2];
        step();
        {end_pool, end_conv} = 2'b00;
        chk("wrong_end_ignored", sv_now(), x.sv);
      end else if (wrrun && k == 2) begin
        cfg_idx = LW'(1);
        cfg_desc = mk(2'd2, 63);
        cfg_we = 1'b1;
        step();
        cfg_we = 1'b0;
      end else step();
    end
    chk("start_hold", sv_now(), x.sv);
    chk("geom_hold", geo_now(), x.geo);
    fc_res_0 = r0;
    fc_res_1 = r1;
    {end_conv, end_pool, end_fc} = x.sv;
    step();
    {end_conv, end_pool, end_fc} = 3'b000;
  endtask
  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end
  initial begin
    int ty[6] = '{0, 1, 0, 0, 1, 2};
    #2;
    chk("rst_ctrl", {sv_now(), done, error, busy, buf_sel, layer_idx}, '0);
    chk("rst_geom", geo_now(), '0);
    chk("rst_nn", {nn_out_0, nn_out_1}, '0);
    #20 rst_n = 1'b1;
    step();
    for (int i = 0; i < 6; i++) wr(i, mk(2'(ty[i]), i));
    chk("idle_busy", busy, 1'b0);
    go(6, 6);
    chk("load_busy", busy, 1'b1);
    for (int i = 0; i < 6; i++) serve(10, i == 0, 1'b0, i == 5 ? 8'h3A : 8'h00, i == 5 ? 8'hC5 : 8'h00);
    chk("done_1", {done, busy}, 2'b11);
    chk("nn_capture", {nn_out_0, nn_out_1}, 16'h3AC5);
    step();
    chk("done_2", done, 1'b1);
    cfg_nlayers = 4'd6;
    start_flag = 1'b1;
    step();
    start_flag = 1'b0;
    chk("done_3", done, 1'b1);
    step();
    chk("done_to_idle", {done, busy}, 2'b00);
    repeat (3) step();
    chk("nn_held", {nn_out_0, nn_out_1, busy}, {16'h3AC5, 1'b0});
    go(1, 0);
    chk("nn_cleared", {nn_out_0, nn_out_1}, '0);
    step();
    chk("to_run1", sv_now(), 3'b100);
    repeat (15) step();
    chk("to_run16", {sv_now(), error}, 4'b1000);
    step();
    chk("to_err", {sv_now(), error, busy}, 5'b00011);
    cfg_nlayers = 4'd1;
    start_flag = 1'b1;
    step();
    start_flag = 1'b0;
    chk("err_ign_start", error, 1'b1);
    abort = 1'b1;
    step();
    abort = 1'b0;
    chk("abort_err", {error, busy}, 2'b00);
    wr(2, mk(2'd3, 2));
    go(4, 2);
    serve(10, 1'b0, 1'b1, 8'h00, 8'h00);
    serve(10, 1'b0, 1'b0, 8'h00, 8'h00);
    chk("ill_load", sv_now(), 3'b000);
    step();
    chk("ill_err", {sv_now(), error, layer_idx}, {3'b000, 1'b1, 3'd2});
    abort = 1'b1;
    step();
    abort = 1'b0;
    chk("ill_abort", {error, busy}, 2'b00);
    wr(0, mk(2'd2, 9));
    go(2, 2);
    serve(10, 1'b0, 1'b0, 8'h11, 8'h22);
    chk("gap_load2", sv_now(), 3'b000);
    step();
    pop(e);
    chk("slot1_kept", {sv_now(), geo_now()}, {e.sv, e.geo});
    chk("nn_mid", {nn_out_0, nn_out_1}, 16'h1122);
    end_pool = 1'b1;
    abort = 1'b1;
    step();
    {end_pool, abort} = 2'b00;
    chk("abort_prio", {sv_now(), done, busy}, 5'b00000);
    chk("abort_nn_kept", {nn_out_0, nn_out_1}, 16'h1122);
    wr(0, mk(2'd0, 0));
    wr(2, mk(2'd0, 2));
    go(6, 3);
    for (int i = 0; i < 3; i++) serve(10, 1'b0, 1'b0, 8'h00, 8'h00);
    step();
    chk("l3_run", {sv_now(), layer_idx}, {3'b100, 3'd3});
    #2 rst_n = 1'b0;
    #1;
    chk("rst_async_ctrl", {sv_now(), done, error, busy, buf_sel, layer_idx}, '0);
    chk("rst_async_geom", geo_now(), '0);
    #10;
    @(negedge clk) rst_n = 1'b1;
    step();
    go(0, 0);
    chk("nl0_idle", busy, 1'b0);
    go(9, 0);
    chk("nl9_idle", busy, 1'b0);
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
